// File: rtl/multicycle_control_unit_if.sv
// Shared instruction encodings and the control-unit <-> datapath/memory bundle.
// The control unit drives the master modport; the datapath side uses slave.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    RTYPE = 6'h00, J     = 6'h02, JAL   = 6'h03, BEQ   = 6'h04, BNE  = 6'h05,
    ADDIU = 6'h09, SLTI  = 6'h0A, SLTIU = 6'h0B, ANDI  = 6'h0C, ORI  = 6'h0D,
    XORI  = 6'h0E, LUI   = 6'h0F, LW    = 6'h23, SW    = 6'h2B, HALT = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'h00, SRL = 6'h02, JR  = 6'h08, ADDU = 6'h21, SUBU = 6'h23,
    AND  = 6'h24, OR  = 6'h25, XOR = 6'h26, NOR  = 6'h27, SLT  = 6'h2A,
    SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [2:0] {
    FETCH  = 3'd0, DECODE = 3'd1, EXEC = 3'd2,
    MEM    = 3'd3, WB     = 3'd4, HALTED = 3'd5
  } state_t;

endpackage

interface multicycle_control_unit_if;
  import cpu_types_pkg::*;

  logic [31:0] imemload;
  logic        ihit;
  logic        dhit;
  logic        zero;
  logic [31:0] ir;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic        ir_wen;
  logic        mdr_wen;
  logic        rf_wen;
  logic        pc_wen;
  logic [4:0]  wsel;
  aluop_t      alu_op;
  logic [1:0]  alu_src;
  logic [1:0]  wdat_sel;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        halt;
  logic        memerr;
  logic        illegal;

  modport master (
    input  imemload, ihit, dhit, zero,
    output ir, imemREN, dmemREN, dmemWEN, ir_wen, mdr_wen, rf_wen, pc_wen,
           wsel, alu_op, alu_src, wdat_sel, pc_sel, state, halt, memerr, illegal
  );

  modport slave (
    output imemload, ihit, dhit, zero,
    input  ir, imemREN, dmemREN, dmemWEN, ir_wen, mdr_wen, rf_wen, pc_wen,
           wsel, alu_op, alu_src, wdat_sel, pc_sel, state, halt, memerr, illegal
  );

endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory
// wait-state watchdog and sticky halt/memerr/illegal status.
module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT     = 16,
  parameter bit          TRAP_ILLEGAL = 1'b1
) (
  input logic                       CLK,
  input logic                       nRST,
  multicycle_control_unit_if.master cu
);

  typedef enum logic [3:0] {
    C_ALU, C_LUI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_HALT, C_ILL
  } iclass_t;

  state_t      state, next_state;
  logic [31:0] ir_q;
  logic [7:0]  wait_cnt;
  logic        memerr_q, illegal_q;
  logic        set_memerr, set_illegal;
  logic        last_wait;

  opcode_t     opcode;
  funct_t      funct;
  iclass_t     cls;
  logic        is_rtype;

  assign opcode    = opcode_t'(ir_q[31:26]);
  assign funct     = funct_t'(ir_q[5:0]);
  assign is_rtype  = (ir_q[31:26] == 6'h00);
  assign last_wait = (wait_cnt == 8'(MAX_WAIT - 1));

  // Instruction class and ALU control depend on ir alone, so the ALU setting
  // stays stable through MEM/WB for datapaths without a result register.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cls        = C_ILL;
    cu.alu_op  = ALU_ADD;
    cu.alu_src = 2'd0;
    case (opcode)
      RTYPE: begin
        case (funct)
          SLL:  begin cls = C_ALU; cu.alu_op = ALU_SLL;  cu.alu_src = 2'd3; end
          SRL:  begin cls = C_ALU; cu.alu_op = ALU_SRL;  cu.alu_src = 2'd3; end
          ADDU: begin cls = C_ALU; cu.alu_op = ALU_ADD;  end
          SUBU: begin cls = C_ALU; cu.alu_op = ALU_SUB;  end
          AND:  begin cls = C_ALU; cu.alu_op = ALU_AND;  end
          OR:   begin cls = C_ALU; cu.alu_op = ALU_OR;   end
          XOR:  begin cls = C_ALU; cu.alu_op = ALU_XOR;  end
          NOR:  begin cls = C_ALU; cu.alu_op = ALU_NOR;  end
          SLT:  begin cls = C_ALU; cu.alu_op = ALU_SLT;  end
          SLTU: begin cls = C_ALU; cu.alu_op = ALU_SLTU; end
          JR:   cls = C_JR;
          default: cls = C_ILL;
        endcase
      end
      ADDIU: begin cls = C_ALU; cu.alu_op = ALU_ADD;  cu.alu_src = 2'd1; end
      ANDI:  begin cls = C_ALU; cu.alu_op = ALU_AND;  cu.alu_src = 2'd2; end
      ORI:   begin cls = C_ALU; cu.alu_op = ALU_OR;   cu.alu_src = 2'd2; end
      XORI:  begin cls = C_ALU; cu.alu_op = ALU_XOR;  cu.alu_src = 2'd2; end
      SLTI:  begin cls = C_ALU; cu.alu_op = ALU_SLT;  cu.alu_src = 2'd1; end
      SLTIU: begin cls = C_ALU; cu.alu_op = ALU_SLTU; cu.alu_src = 2'd1; end
      LUI:   cls = C_LUI;
      LW:    begin cls = C_LW; cu.alu_op = ALU_ADD; cu.alu_src = 2'd1; end
      SW:    begin cls = C_SW; cu.alu_op = ALU_ADD; cu.alu_src = 2'd1; end
      BEQ:   begin cls = C_BEQ; cu.alu_op = ALU_SUB; end
      BNE:   begin cls = C_BNE; cu.alu_op = ALU_SUB; end
      J:     cls = C_J;
      JAL:   cls = C_JAL;
      HALT:  cls = C_HALT;
      default: cls = C_ILL;
    endcase
  end

  always_comb begin
    next_state  = state;
    set_memerr  = 1'b0;
    set_illegal = 1'b0;
    cu.imemREN  = 1'b0;
    cu.dmemREN  = 1'b0;
    cu.dmemWEN  = 1'b0;
    cu.ir_wen   = 1'b0;
    cu.mdr_wen  = 1'b0;
    cu.rf_wen   = 1'b0;
    cu.pc_wen   = 1'b0;
    cu.wsel     = 5'd0;
    cu.wdat_sel = 2'd0;
    cu.pc_sel   = 2'd0;
    case (state)
      FETCH: begin
        cu.imemREN = 1'b1;
        if (cu.ihit) begin
          cu.ir_wen  = 1'b1;
          next_state = DECODE;
        end else if (last_wait) begin
          next_state = HALTED;
          set_memerr = 1'b1;
        end
      end
      DECODE: begin
        case (cls)
          C_HALT: next_state = HALTED;
          C_J: begin
            cu.pc_wen = 1'b1; cu.pc_sel = 2'd2; next_state = FETCH;
          end
          C_JAL: begin
            cu.pc_wen = 1'b1; cu.pc_sel = 2'd2;
            cu.rf_wen = 1'b1; cu.wsel = 5'd31; cu.wdat_sel = 2'd3;
            next_state = FETCH;
          end
          C_JR: begin
            cu.pc_wen = 1'b1; cu.pc_sel = 2'd3; next_state = FETCH;
          end
          C_ILL: begin
            if (TRAP_ILLEGAL) begin
              next_state  = HALTED;
              set_illegal = 1'b1;
            end else begin
              cu.pc_wen  = 1'b1;
              next_state = FETCH;
            end
          end
          default: next_state = EXEC;
        endcase
      end
      EXEC: begin
        case (cls)
          C_BEQ: begin
            cu.pc_wen = 1'b1; cu.pc_sel = cu.zero ? 2'd1 : 2'd0; next_state = FETCH;
          end
          C_BNE: begin
            cu.pc_wen = 1'b1; cu.pc_sel = cu.zero ? 2'd0 : 2'd1; next_state = FETCH;
          end
          C_LW, C_SW: next_state = MEM;
          default:    next_state = WB;
        endcase
      end
      MEM: begin
        cu.dmemREN = (cls == C_LW);
        cu.dmemWEN = (cls != C_LW);
        if (cu.dhit) begin
          if (cls == C_LW) begin
            cu.mdr_wen = 1'b1; next_state = WB;
          end else begin
            cu.pc_wen = 1'b1; next_state = FETCH;
          end
        end else if (last_wait) begin
          next_state = HALTED;
          set_memerr = 1'b1;
        end
      end
      WB: begin
        cu.wsel     = is_rtype ? ir_q[15:11] : ir_q[20:16];
        cu.wdat_sel = (cls == C_LW) ? 2'd1 : (cls == C_LUI) ? 2'd2 : 2'd0;
        cu.rf_wen   = 1'b1;
        cu.pc_wen   = 1'b1;
        next_state  = FETCH;
      end
      HALTED:  next_state = HALTED;
      default: next_state = FETCH;
    endcase
  end

  // The watchdog restarts on every state change, so each FETCH/MEM visit gets
  // its own MAX_WAIT budget.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: ir is reset too so DECODE never sees X after an early abort.
      state     <= FETCH;
      ir_q      <= '0;
      wait_cnt  <= '0;
      memerr_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      state <= next_state;
      if (cu.ir_wen) ir_q <= cu.imemload;
      if (next_state != state) wait_cnt <= '0;
      else if (state == FETCH || state == MEM) wait_cnt <= wait_cnt + 8'd1;
      if (set_memerr)  memerr_q  <= 1'b1;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  assign cu.ir      = ir_q;
  assign cu.state   = state;
  assign cu.halt    = (state == HALTED);
  assign cu.memerr  = memerr_q;
  assign cu.illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-instruction sequencing,
// watchdog boundary, illegal-opcode handling and asynchronous abort.
module tb_multicycle_control_unit;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  multicycle_control_unit_if bus ();
  multicycle_control_unit_if bus_nt ();

  multicycle_control_unit #(.MAX_WAIT(4), .TRAP_ILLEGAL(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .cu(bus)
  );
  multicycle_control_unit #(.MAX_WAIT(16), .TRAP_ILLEGAL(1'b0)) dut_nt (
    .CLK(CLK), .nRST(nRST), .cu(bus_nt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pcw_cnt = 0, dren_cnt = 0, mdr_cnt = 0;
  int snap_pcw, snap_dren, snap_mdr;

  always @(negedge CLK) begin
    if (bus.pc_wen)  pcw_cnt++;
    if (bus.dmemREN) dren_cnt++;
    if (bus.mdr_wen) mdr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset;
    @(posedge CLK);
    #2 nRST = 1'b0;
    bus.ihit = 1'b0; bus.dhit = 1'b0; bus.zero = 1'b0;
    @(posedge CLK);
    #2 nRST = 1'b1;
  endtask

  // Presents an instruction with a zero-wait ihit; returns in DECODE at +2.
  task automatic fetch(input string tag, input logic [31:0] instr);
    bus.imemload = instr;
    bus.ihit     = 1'b1;
    #1 check({tag, "_irwen"}, bus.ir_wen, 1);
    tick();
    bus.ihit = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    bus.imemload = '0; bus.ihit = 1'b0; bus.dhit = 1'b0; bus.zero = 1'b0;
    bus_nt.imemload = '0; bus_nt.ihit = 1'b0; bus_nt.dhit = 1'b0; bus_nt.zero = 1'b0;

    // Reset state
    tick(); #1;
    check("rst_state", bus.state, 0);
    check("rst_ir", bus.ir, 0);
    check("rst_imemren", bus.imemREN, 1);
    check("rst_enables", {bus.ir_wen, bus.mdr_wen, bus.rf_wen, bus.pc_wen,
                          bus.dmemREN, bus.dmemWEN}, 0);
    check("rst_flags", {bus.halt, bus.memerr, bus.illegal}, 0);
    @(posedge CLK);
    #2 nRST = 1'b1;

    // Illegal opcode executes as a NOP when not trapped
    bus_nt.imemload = 32'h4C000000;
    bus_nt.ihit = 1'b1;
    tick();
    bus_nt.ihit = 1'b0;
    #1;
    check("nt_dec_state", bus_nt.state, 1);
    check("nt_dec_pcwen", bus_nt.pc_wen, 1);
    check("nt_dec_pcsel", bus_nt.pc_sel, 0);
    tick(); #1;
    check("nt_state", bus_nt.state, 0);
    check("nt_flags", {bus_nt.halt, bus_nt.illegal}, 0);
    do_reset();

    // addu $3,$1,$2
    snap_pcw = pcw_cnt;
    fetch("addu", 32'h00221821); #1;
    check("addu_dec_state", bus.state, 1);
    check("addu_ir", bus.ir, 32'h00221821);
    tick(); #1;
    check("addu_exec_state", bus.state, 2);
    check("addu_alu", bus.alu_op, ALU_ADD);
    check("addu_src", bus.alu_src, 0);
    check("addu_exec_pcwen", bus.pc_wen, 0);
    tick(); #1;
    check("addu_wb_state", bus.state, 4);
    check("addu_wb", {bus.rf_wen, bus.pc_wen, bus.wsel, bus.wdat_sel, bus.pc_sel},
          {1'b1, 1'b1, 5'd3, 2'd0, 2'd0});
    tick(); #1;
    check("addu_done", bus.state, 0);
    check("addu_pcw", pcw_cnt - snap_pcw, 1);

    // lw $3,4($1) with dhit three cycles late
    fetch("lw", 32'h8C230004);
    tick(); #1;
    check("lw_exec", {bus.alu_op, bus.alu_src}, {ALU_ADD, 2'd1});
    tick();
    snap_dren = dren_cnt; snap_mdr = mdr_cnt;
    #1 check("lw_mem_state", bus.state, 3);
    check("lw_mem_ren", bus.dmemREN, 1);
    tick(); tick(); tick();
    bus.dhit = 1'b1;
    #1 check("lw_mdrwen", bus.mdr_wen, 1);
    tick();
    bus.dhit = 1'b0;
    #1;
    check("lw_wb_state", bus.state, 4);
    check("lw_wb", {bus.rf_wen, bus.wsel, bus.wdat_sel}, {1'b1, 5'd3, 2'd1});
    check("lw_ren_cycles", dren_cnt - snap_dren, 4);
    check("lw_mdr_cycles", mdr_cnt - snap_mdr, 1);
    tick();

    // beq taken / not taken, bne taken
    fetch("beq1", 32'h10220003);
    tick();
    bus.zero = 1'b1;
    #1 check("beq1_exec", {bus.pc_wen, bus.pc_sel}, {1'b1, 2'd1});
    tick(); #1;
    check("beq1_state", bus.state, 0);
    fetch("beq0", 32'h10220003);
    tick();
    bus.zero = 1'b0;
    #1 check("beq0_exec", {bus.pc_wen, bus.pc_sel}, {1'b1, 2'd0});
    tick();
    fetch("bne0", 32'h14220003);
    tick(); #1;
    check("bne0_exec", {bus.pc_wen, bus.pc_sel}, {1'b1, 2'd1});
    tick();

    // Jumps resolve in DECODE
    fetch("j", 32'h08000010); #1;
    check("j_dec", {bus.pc_wen, bus.pc_sel, bus.rf_wen}, {1'b1, 2'd2, 1'b0});
    tick(); #1;
    check("j_state", bus.state, 0);
    fetch("jal", 32'h0C000010); #1;
    check("jal_dec", {bus.pc_wen, bus.pc_sel, bus.rf_wen, bus.wsel, bus.wdat_sel},
          {1'b1, 2'd2, 1'b1, 5'd31, 2'd3});
    tick();
    fetch("jr", 32'h03E00008); #1;
    check("jr_dec", {bus.pc_wen, bus.pc_sel}, {1'b1, 2'd3});
    tick();

    // lui / ori / sll
    fetch("lui", 32'h3C031234);
    tick(); tick(); #1;
    check("lui_wb", {bus.state, bus.wsel, bus.wdat_sel}, {3'd4, 5'd3, 2'd2});
    tick();
    fetch("ori", 32'h34230005);
    tick(); #1;
    check("ori_exec", {bus.alu_op, bus.alu_src}, {ALU_OR, 2'd2});
    tick(); #1;
    check("ori_wb", {bus.wsel, bus.wdat_sel}, {5'd3, 2'd0});
    tick();
    fetch("sll", 32'h00031080);
    tick(); #1;
    check("sll_exec", {bus.alu_op, bus.alu_src}, {ALU_SLL, 2'd3});
    tick(); #1;
    check("sll_wb", bus.wsel, 2);
    tick();

    // sw aborted by reset in MEM
    fetch("sw", 32'hAC230004);
    tick(); tick(); #1;
    check("sw_mem_wen", bus.dmemWEN, 1);
    snap_pcw = pcw_cnt;
    #1 nRST = 1'b0;
    #1;
    check("sw_abort_wen", bus.dmemWEN, 0);
    check("sw_abort_state", bus.state, 0);
    check("sw_abort_pcwen", bus.pc_wen, 0);
    @(posedge CLK);
    #2 nRST = 1'b1;
    tick(); #1;
    check("sw_abort_pcw", pcw_cnt - snap_pcw, 0);
    do_reset();

    // Fetch watchdog: four missed cycles halt with memerr
    snap_pcw = pcw_cnt;
    tick(); tick(); tick(); #1;
    check("to_pre_state", bus.state, 0);
    tick(); #1;
    check("to_state", bus.state, 5);
    check("to_flags", {bus.halt, bus.memerr, bus.illegal}, {1'b1, 1'b1, 1'b0});
    check("to_imemren", bus.imemREN, 0);
    bus.ihit = 1'b1;
    #1 check("halted_irwen", bus.ir_wen, 0);
    tick(); #1;
    check("halted_stays", bus.state, 5);
    check("halted_pcw", pcw_cnt - snap_pcw, 0);
    do_reset();

    // Hit on the timeout cycle wins; the fetched word is HALT
    tick(); tick(); tick();
    bus.imemload = 32'hFC000000;
    bus.ihit = 1'b1;
    tick();
    bus.ihit = 1'b0;
    #1;
    check("hit4_state", bus.state, 1);
    check("hit4_memerr", bus.memerr, 0);
    tick(); #1;
    check("halt_instr", {bus.state, bus.halt, bus.memerr, bus.illegal},
          {3'd5, 1'b1, 1'b0, 1'b0});
    do_reset();

    // Trapped illegal opcode
    fetch("ill", 32'h4C000000);
    tick(); #1;
    check("ill_state", bus.state, 5);
    check("ill_flags", {bus.halt, bus.memerr, bus.illegal}, {1'b1, 1'b0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
